// File: rtl/roc_decoder.sv
// -----------------------------------------------------------------------------
// roc_decoder
//   Receive side of the rank-order-coded AER link. Accepts 10-bit AER events
//   over a 4-phase REQ/ACK handshake, detects the two-marker preamble that
//   opens a frame, and records the arrival order (rank) of each pixel index.
//
// Ports
//   CLK          system clock
//   RST          synchronous active-high reset
//   AERIN_ADDR   AER address, stable while AERIN_REQ is high
//   AERIN_REQ    AER request (asynchronous, synchronised internally)
//   AERIN_ACK    AER acknowledge (registered)
//   RANK_ADDR    pixel index to read
//   RANK_DATA    rank of RANK_ADDR (0 = first to fire), combinational read
//   RANK_VALID   RANK_ADDR has fired in the current frame
//   RANK_COUNT   unique pixels received in the current frame
//   FRAME_ACTIVE frame in progress
//   FRAME_DONE   all IMAGE_SIZE pixels received
//   DUP_ERR      sticky duplicate-index flag for the current frame
//   DROP_PULSE   one-cycle pulse when an event is discarded
// -----------------------------------------------------------------------------
module roc_decoder #(
  parameter int         IMAGE_SIZE      = 256,
  parameter int         IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter logic [9:0] MARKER          = 10'h1FF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [9:0]                 AERIN_ADDR,
  input  logic                       AERIN_REQ,
  output logic                       AERIN_ACK,
  input  logic [IMAGE_SIZE_BITS-1:0] RANK_ADDR,
  output logic [IMAGE_SIZE_BITS-1:0] RANK_DATA,
  output logic                       RANK_VALID,
  output logic [IMAGE_SIZE_BITS:0]   RANK_COUNT,
  output logic                       FRAME_ACTIVE,
  output logic                       FRAME_DONE,
  output logic                       DUP_ERR,
  output logic                       DROP_PULSE
);

  // Storage is sized to the full index space so any RANK_ADDR reads safely;
  // entries at or above IMAGE_SIZE are never written and stay invalid.
  localparam int DEPTH = 1 << IMAGE_SIZE_BITS;
  localparam logic [9:0]               IMG_SIZE_A = 10'(IMAGE_SIZE);
  localparam logic [IMAGE_SIZE_BITS:0] IMG_SIZE_C = (IMAGE_SIZE_BITS + 1)'(IMAGE_SIZE);

  localparam logic       HS_IDLE = 1'b0;
  localparam logic       HS_HOLD = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // ---------------------------------------------------------------------------
  // Request synchroniser and handshake
  // ---------------------------------------------------------------------------
  logic       req_meta_q;
  logic       req_s_q;
  logic       hs_state_q;
  logic       ack_q;
  logic [9:0] addr_q;
  logic       ev_valid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      hs_state_q <= HS_IDLE;
      ack_q      <= 1'b0;
      addr_q     <= '0;
      ev_valid_q <= 1'b0;
    end else begin
      req_meta_q <= AERIN_REQ;
      req_s_q    <= req_meta_q;
      ev_valid_q <= 1'b0;
      case (hs_state_q)
        HS_IDLE: begin
          // AERIN_ADDR has been stable since before REQ rose, so it is safe
          // to capture directly once the synchronised request arrives.
          if (req_s_q) begin
            addr_q     <= AERIN_ADDR;
            ev_valid_q <= 1'b1;
            ack_q      <= 1'b1;
            hs_state_q <= HS_HOLD;
          end
        end
        default: begin
          if (!req_s_q) begin
            ack_q      <= 1'b0;
            hs_state_q <= HS_IDLE;
          end
        end
      endcase
    end
  end

  assign AERIN_ACK = ack_q;

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  logic [1:0]                 state_q, state_d;
  logic [IMAGE_SIZE_BITS:0]   count_q, count_d;
  logic                       dup_q, dup_d;
  logic                       drop_q, drop_d;
  logic [DEPTH-1:0]           valid_q, valid_d;
  logic [IMAGE_SIZE_BITS-1:0] rank_mem [DEPTH];

  logic                       wr_en;
  logic                       clr_all;
  logic                       is_marker;
  logic                       in_range;
  logic [IMAGE_SIZE_BITS-1:0] ev_idx;
  logic [IMAGE_SIZE_BITS:0]   count_inc;

  assign is_marker = (addr_q == MARKER);
  assign in_range  = (addr_q < IMG_SIZE_A);
  assign ev_idx    = addr_q[IMAGE_SIZE_BITS-1:0];
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dup_d   = dup_q;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    clr_all = 1'b0;
    if (ev_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (is_marker) state_d = ST_ARM;
          else           drop_d  = 1'b1;
        end
        ST_ARM: begin
          if (is_marker) begin
            state_d = ST_RECV;
            clr_all = 1'b1;
            count_d = '0;
            dup_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            drop_d  = 1'b1;
          end
        end
        ST_RECV: begin
          // The marker is tested first; it lies outside the pixel range.
          if (is_marker) begin
            state_d = ST_ARM;
          end else if (!in_range) begin
            drop_d = 1'b1;
          end else if (valid_q[ev_idx]) begin
            dup_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_inc;
            if (count_inc == IMG_SIZE_C) state_d = ST_DONE;
          end
        end
        default: begin
          if (is_marker) state_d = ST_ARM;
          else           drop_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dup_q   <= 1'b0;
      drop_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
    end
  end

  // Per-pixel valid bit: cleared on frame start, set on first write.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_d[gi] = clr_all ? 1'b0
                         : (valid_q[gi] | (wr_en && (ev_idx == IMAGE_SIZE_BITS'(gi))));
    end
  endgenerate

  // Rank storage is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) rank_mem[ev_idx] <= count_q[IMAGE_SIZE_BITS-1:0];
  end

  assign RANK_DATA    = rank_mem[RANK_ADDR];
  assign RANK_VALID   = valid_q[RANK_ADDR];
  assign RANK_COUNT   = count_q;
  assign FRAME_ACTIVE = (state_q == ST_RECV);
  assign FRAME_DONE   = (state_q == ST_DONE);
  assign DUP_ERR      = dup_q;
  assign DROP_PULSE   = drop_q;

endmodule

// File: tb/tb_roc_decoder.sv
module tb_roc_decoder;

  localparam int N = 256;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] AERIN_ADDR = '0;
  logic       AERIN_REQ = 1'b0;
  logic       AERIN_ACK;
  logic [7:0] RANK_ADDR = '0;
  logic [7:0] RANK_DATA;
  logic       RANK_VALID;
  logic [8:0] RANK_COUNT;
  logic       FRAME_ACTIVE, FRAME_DONE, DUP_ERR, DROP_PULSE;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;

  roc_decoder #(.IMAGE_SIZE(N)) dut (
    .CLK(CLK), .RST(RST),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .RANK_ADDR(RANK_ADDR), .RANK_DATA(RANK_DATA), .RANK_VALID(RANK_VALID),
    .RANK_COUNT(RANK_COUNT), .FRAME_ACTIVE(FRAME_ACTIVE), .FRAME_DONE(FRAME_DONE),
    .DUP_ERR(DUP_ERR), .DROP_PULSE(DROP_PULSE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DROP_PULSE === 1'b1) drop_cnt++;

  // ---------------- reference model (event-level) ----------------
  bit m_valid [N];
  int m_rank  [N];
  int m_count;
  bit m_dup;
  bit m_armed;     // one marker seen, waiting for the second
  bit m_in_frame;  // a frame has been opened and not interrupted

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_count = 0; m_dup = 0; m_armed = 0; m_in_frame = 0;
  endfunction

  function automatic int m_apply(input int a);
    int drop = 0;
    if (a == 'h1FF) begin
      if (m_armed) begin
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_count = 0; m_dup = 0; m_armed = 0; m_in_frame = 1;
      end else begin
        m_armed = 1; m_in_frame = 0;
      end
    end else if (m_armed) begin
      m_armed = 0; drop = 1;
    end else if (!m_in_frame || m_count == N) begin
      drop = 1;
    end else if (a >= N) begin
      drop = 1;
    end else if (m_valid[a]) begin
      m_dup = 1;
    end else begin
      m_rank[a] = m_count; m_valid[a] = 1; m_count++;
    end
    return drop;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; AERIN_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m_reset();
  endtask

  task automatic send_event(input logic [9:0] a, output int drops, output int exp_drop);
    int d0;
    int n;
    @(negedge CLK);
    d0 = drop_cnt;
    AERIN_ADDR = a; AERIN_REQ = 1'b1;
    n = 0;
    while (AERIN_ACK !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    chk("ack_rise", int'(AERIN_ACK === 1'b1), 1);
    AERIN_REQ = 1'b0;
    n = 0;
    while (AERIN_ACK !== 1'b0 && n < 20) begin @(negedge CLK); n++; end
    chk("ack_fall", int'(AERIN_ACK === 1'b0), 1);
    repeat (2) @(negedge CLK);
    drops = drop_cnt - d0;
    exp_drop = m_apply(int'(a));
    $display("event addr=%03h drops=%0d count=%0d active=%0d done=%0d dup=%0d",
             a, drops, RANK_COUNT, FRAME_ACTIVE, FRAME_DONE, DUP_ERR);
  endtask

  task automatic send(input logic [9:0] a);
    int d, e;
    send_event(a, d, e);
  endtask

  task automatic read_rank(input int rd, output int v, output int dat);
    RANK_ADDR = 8'(rd);
    #1;
    v = int'(RANK_VALID);
    dat = int'(RANK_DATA);
  endtask

  task automatic chk_model(input int rd);
    int v, dat;
    chk("count", int'(RANK_COUNT), m_count);
    chk("active", int'(FRAME_ACTIVE), int'(m_in_frame && m_count < N));
    chk("done", int'(FRAME_DONE), int'(m_in_frame && m_count == N));
    chk("dup", int'(DUP_ERR), int'(m_dup));
    read_rank(rd, v, dat);
    chk("rvalid", v, int'(m_valid[rd]));
    if (m_valid[rd]) chk("rdata", dat, m_rank[rd]);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [9:0] addr;
    int rd;
    int cnt;
    int act;
    int done;
    int dup;
    int drop;
    int rv;
    int rdat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int d, e, v, dat, others;

    vecs[0]  = '{10'h1FF,  0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{10'h012, 12, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{10'h1FF, 12, 0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{10'h1FF,  9, 0, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{10'h009,  9, 1, 1, 0, 0, 0, 1, 0};
    vecs[5]  = '{10'h007,  7, 2, 1, 0, 0, 0, 1, 1};
    vecs[6]  = '{10'h007,  7, 2, 1, 0, 1, 0, 1, 1};
    vecs[7]  = '{10'h12C, 12, 2, 1, 0, 1, 1, 0, 0};
    vecs[8]  = '{10'h1FF,  9, 2, 0, 0, 1, 0, 1, 0};
    vecs[9]  = '{10'h1FF,  9, 0, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{10'h002,  2, 1, 1, 0, 0, 0, 1, 0};

    // Reset state
    do_reset();
    chk("rst_ack", int'(AERIN_ACK), 0);
    chk("rst_count", int'(RANK_COUNT), 0);
    chk("rst_active", int'(FRAME_ACTIVE), 0);
    chk("rst_done", int'(FRAME_DONE), 0);
    chk("rst_dup", int'(DUP_ERR), 0);
    chk("rst_drop", int'(DROP_PULSE), 0);
    read_rank(0, v, dat);
    chk("rst_valid0", v, 0);

    // Broken preamble, duplicate, out-of-range, restart
    for (int i = 0; i < 11; i++) begin
      send_event(vecs[i].addr, d, e);
      chk("tbl_drop", d, vecs[i].drop);
      chk("tbl_count", int'(RANK_COUNT), vecs[i].cnt);
      chk("tbl_active", int'(FRAME_ACTIVE), vecs[i].act);
      chk("tbl_done", int'(FRAME_DONE), vecs[i].done);
      chk("tbl_dup", int'(DUP_ERR), vecs[i].dup);
      read_rank(vecs[i].rd, v, dat);
      chk("tbl_rvalid", v, vecs[i].rv);
      if (vecs[i].rv != 0) chk("tbl_rdata", dat, vecs[i].rdat);
    end

    // Handshake timing; a long REQ yields exactly one event
    do_reset();
    send(10'h1FF);
    send(10'h1FF);
    @(negedge CLK);
    AERIN_ADDR = 10'h009; AERIN_REQ = 1'b1;
    @(negedge CLK); chk("hs_rise_e1", int'(AERIN_ACK), 0);
    @(negedge CLK); chk("hs_rise_e2", int'(AERIN_ACK), 0);
    @(negedge CLK); chk("hs_rise_e3", int'(AERIN_ACK), 1);
    repeat (20) @(negedge CLK);
    chk("hs_hold", int'(AERIN_ACK), 1);
    AERIN_REQ = 1'b0;
    @(negedge CLK); chk("hs_fall_e1", int'(AERIN_ACK), 1);
    @(negedge CLK); chk("hs_fall_e2", int'(AERIN_ACK), 1);
    @(negedge CLK); chk("hs_fall_e3", int'(AERIN_ACK), 0);
    repeat (3) @(negedge CLK);
    void'(m_apply(9));
    chk("hs_one_write", int'(RANK_COUNT), 1);
    chk_model(9);

    // Reset while ACK is high discards the event in flight
    @(negedge CLK);
    AERIN_ADDR = 10'h004; AERIN_REQ = 1'b1;
    for (int n = 0; n < 20 && AERIN_ACK !== 1'b1; n++) @(negedge CLK);
    chk("mid_ack_high", int'(AERIN_ACK === 1'b1), 1);
    RST = 1'b1; AERIN_REQ = 1'b0;
    @(negedge CLK);
    chk("mid_ack_drop", int'(AERIN_ACK), 0);
    chk("mid_count", int'(RANK_COUNT), 0);
    chk("mid_active", int'(FRAME_ACTIVE), 0);
    RST = 1'b0;
    m_reset();
    repeat (5) @(negedge CLK);
    chk("mid_ack_idle", int'(AERIN_ACK), 0);
    chk_model(4);
    send(10'h1FF); send(10'h1FF); send(10'h004);
    read_rank(4, v, dat);
    chk("mid_rank4_valid", v, 1);
    chk("mid_rank4", dat, 0);
    chk_model(4);

    // Full frame
    do_reset();
    send(10'h1FF); send(10'h1FF); send(10'h005); send(10'h003);
    for (int i = 0; i < N; i++) if (i != 5 && i != 3) send(10'(i));
    read_rank(5, v, dat);   chk("full_rank5", dat, 0);
    read_rank(3, v, dat);   chk("full_rank3", dat, 1);
    read_rank(0, v, dat);   chk("full_rank0", dat, 2);
    read_rank(255, v, dat); chk("full_rank255", dat, 255);
    chk("full_count", int'(RANK_COUNT), 256);
    chk("full_done", int'(FRAME_DONE), 1);
    chk("full_active", int'(FRAME_ACTIVE), 0);
    chk("full_dup", int'(DUP_ERR), 0);
    send_event(10'h00A, d, e);
    chk("done_drop", d, 1);
    chk("done_count_hold", int'(RANK_COUNT), 256);
    chk_model(10);
    send(10'h1FF);
    chk("done_to_arm", int'(FRAME_DONE), 0);

    // Early restart 40 pixels into a frame
    do_reset();
    send(10'h1FF); send(10'h1FF);
    for (int i = 0; i < 40; i++) send(10'(i * 3));
    send(10'h003);
    chk("early_dup_set", int'(DUP_ERR), 1);
    send(10'h1FF); send(10'h1FF); send(10'h002);
    chk("early_count", int'(RANK_COUNT), 1);
    chk("early_dup_clr", int'(DUP_ERR), 0);
    read_rank(2, v, dat);
    chk("early_rank2", dat, 0);
    others = 0;
    for (int a = 0; a < N; a++) begin
      read_rank(a, v, dat);
      if (v != 0 && a != 2) others++;
    end
    chk("early_others_valid", others, 0);

    // Randomised events against the model
    do_reset();
    for (int k = 0; k < 300; k++) begin
      int r;
      int a;
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        send_event(10'h1FF, d, e);
        chk("rnd_drop", d, e);
        if (r < 6) begin
          send_event(10'h1FF, d, e);
          chk("rnd_drop", d, e);
        end
      end else begin
        if (r < 65)      a = int'($urandom_range(0, 31));
        else if (r < 80) a = int'($urandom_range(0, N - 1));
        else if (r < 90) a = int'($urandom_range(N, 510));
        else             a = int'($urandom_range(512, 1023));
        send_event(10'(a), d, e);
        chk("rnd_drop", d, e);
      end
      chk_model(int'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
